// File: rtl/weight_fetch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : weight_fetch_ctrl_pkg                                        |
// | Description : Shared types and constants for the weight fetch controller.  |
// |               FSM state encoding and the SRAM word address stride.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package weight_fetch_ctrl_pkg;

  // Byte stride between consecutive 32-bit weight words.
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wfc_state_e;

endpackage
`default_nettype wire

// File: rtl/wfc_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wfc_skid_fifo                                                |
// | Description : 2-entry output buffer between SRAM read data and the weight  |
// |               stream. Push and pop may occur in the same cycle.            |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : clk, rst_n        clock / async active-low reset             |
// |               push, push_data   write an entry (ignored when full)         |
// |               pop               remove head entry (ignored when empty)     |
// |               head              current head entry                         |
// |               count, empty      occupancy (0..2)                           |
// +----------------------------------------------------------------------------+
module wfc_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/weight_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : weight_fetch_ctrl                                            |
// | Description : Streams a job of 32-bit weight words from the weight SRAM    |
// |               (1-cycle read latency) to the PE-array loader over           |
// |               valid/ready, flagging the last word. The host write port     |
// |               shares the SRAM and always wins the port.                    |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : clk, rst_n             clock / async active-low reset        |
// |               start, base_addr,      job launch (sampled in IDLE only)     |
// |               num_words                                                    |
// |               busy, done             job status                            |
// |               host_wen/addr/d        host write request                    |
// |               sram_wen/addr/d, q     SRAM port                             |
// |               w_valid/ready/data/last  weight stream                       |
// +----------------------------------------------------------------------------+
module weight_fetch_ctrl
  import weight_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  input  logic              host_wen,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_d,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last
);

  wfc_state_e        state;
  logic [ADDR_W-1:0] next_addr;      // address of the next word to issue
  logic [ADDR_W-1:0] read_addr;      // last address presented for a read
  logic [CNT_W-1:0]  num_r;
  logic [CNT_W-1:0]  issued;
  logic              inflight;       // a read was issued last cycle; sram_q holds it now
  logic              inflight_last;

  logic              issue;
  logic              issue_last;
  logic              pop;
  logic [DATA_W:0]   fifo_head;
  logic [1:0]        fifo_count;
  logic              fifo_empty;

  assign pop        = w_valid && w_ready;
  assign issue_last = (issued == num_r - CNT_W'(1));

  // Credit check: buffered + in-flight words must fit in the 2-entry FIFO once
  // the word leaving this cycle is accounted for. Counting the pop keeps the
  // stream at one word per cycle when w_ready stays high; an issue only ever
  // happens with at most one word left after the pop, so the FIFO cannot
  // overflow when the read data lands next cycle.
  assign issue = (state == ST_FETCH) && !host_wen &&
                 (({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  // Host owns the SRAM port whenever it asks; otherwise present the issuing
  // read address, else hold the previous one.
  assign sram_wen  = host_wen;
  assign sram_addr = host_wen ? host_addr : (issue ? next_addr : read_addr);
  assign sram_d    = host_wen ? host_d : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      num_r         <= '0;
      issued        <= '0;
      next_addr     <= '0;
      read_addr     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && issue_last;
      if (issue) begin
        read_addr <= next_addr;
        next_addr <= next_addr + ADDR_W'(WORD_BYTES);  // wraps mod 2^ADDR_W
        issued    <= issued + CNT_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_r     <= num_words;
            issued    <= '0;
            next_addr <= base_addr;
            busy      <= 1'b1;
            if (num_words == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (issue && issue_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && fifo_head[DATA_W]) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  wfc_skid_fifo #(
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({inflight_last, sram_q}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign w_valid = !fifo_empty;
  assign w_data  = fifo_head[DATA_W-1:0];
  // The head slot keeps stale contents after a pop; only flag last on a live word.
  assign w_last  = w_valid && fifo_head[DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_weight_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_weight_fetch_ctrl                                         |
// | Description : Self-checking bench for weight_fetch_ctrl with a behavioural |
// |               SRAM and a queue-based expected word stream.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_weight_fetch_ctrl;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  num_words = '0;
  logic              busy;
  logic              done;
  logic              host_wen = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_d = '0;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q = '0;
  logic              w_valid;
  logic              w_ready = 1'b0;
  logic [DATA_W-1:0] w_data;
  logic              w_last;

  weight_fetch_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .host_wen  (host_wen),
    .host_addr (host_addr),
    .host_d    (host_d),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_d    (sram_d),
    .sram_q    (sram_q),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_last    (w_last)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural SRAM: untouched words read back a unique address-derived pattern.
  logic [31:0] mem [int];

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {~a, a};
  endfunction

  always @(posedge clk) begin
    if (sram_wen) mem[int'(sram_addr)] = sram_d;
    else          sram_q <= mem_rd(sram_addr);
  end

  // Expected stream {last, data} and per-job observations.
  logic [32:0] exp_q [$];
  logic [32:0] exp_e;
  int job_words = 0;
  int beats_job = 0;
  int first_valid_cyc = -1;
  int first_hs_cyc = -1;
  int last_hs_cyc = -1;
  int busy_cyc = 0;
  int done_cnt = 0;
  int start_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cyc++;
      if (w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (w_valid && w_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'd1, 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("w_data", w_data, exp_e[31:0]);
          check("w_last", w_last, exp_e[32]);
        end
        check("busy_during_beat", busy, 1);
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        beats_job++;
      end
      if (done) begin
        done_cnt++;
        check("done_drained", exp_q.size(), 0);
        check("busy_at_done", busy, 1);
        if (job_words > 0) check("done_after_last", cyc - last_hs_cyc, 1);
        else               check("zero_job_no_beats", beats_job, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] b, input int n);
    int g;
    logic [15:0] a;
    g = 0;
    while (busy && g < 400) begin
      tick();
      g++;
    end
    if (busy) check("idle_before_start", busy, 0);
    for (int i = 0; i < n; i++) begin
      a = b + 16'(i * 4);
      exp_q.push_back({(i == n - 1), mem_rd(a)});
    end
    job_words = n;
    beats_job = 0;
    first_valid_cyc = -1;
    first_hs_cyc = -1;
    last_hs_cyc = -1;
    busy_cyc = 0;
    start_cyc = cyc;
    base_addr = b;
    num_words = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready held high, 1: toggling, 2: random
  task automatic wait_done(input int mode, input bit host_rand);
    int target;
    int g;
    target = done_cnt + 1;
    g = 0;
    while (done_cnt < target && g < 400) begin
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = ~w_ready;
        default: w_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (host_rand && $urandom_range(0, 5) == 0) begin
        host_wen  = 1'b1;
        host_addr = 16'h8000 | 16'($urandom_range(0, 255) * 4);
        host_d    = $urandom;
      end else begin
        host_wen = 1'b0;
      end
      tick();
      g++;
    end
    host_wen = 1'b0;
    check("done_seen", done_cnt >= target, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    int g;
    int n;
    logic [15:0] b;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_w_last", w_last, 0);
    check("rst_w_data", w_data, 0);
    check("rst_sram_wen", sram_wen, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_d", sram_d, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 1: basic job, ready held high
    w_ready = 1'b1;
    start_job(16'h0000, 4);
    wait_done(0, 1'b0);
    check("t1_latency", first_valid_cyc - start_cyc, 3);
    check("t1_back_to_back", last_hs_cyc - first_hs_cyc, 3);
    check("t1_beats", beats_job, 4);

    // 2: toggling ready, plus a start pulse while busy that must be ignored
    start_job(16'h0040, 6);
    base_addr = 16'h3000;
    num_words = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1, 1'b0);
    check("t2_beats", beats_job, 6);

    // 3: address wrap
    start_job(16'hFFF8, 3);
    wait_done(0, 1'b0);
    check("t3_beats", beats_job, 3);

    // 4: host write mid-fetch, then read it back
    start_job(16'h0200, 8);
    w_ready   = 1'b1;
    host_wen  = 1'b1;
    host_addr = 16'h0100;
    host_d    = 32'hA5A5A5A5;
    #1;
    check("t4_sram_wen", sram_wen, 1);
    check("t4_sram_addr", sram_addr, 32'h0100);
    check("t4_sram_d", sram_d, 32'hA5A5A5A5);
    tick();
    tick();
    host_wen = 1'b0;
    wait_done(0, 1'b0);
    check("t4_beats", beats_job, 8);
    start_job(16'h0100, 1);
    exp_q[0] = {1'b1, 32'hA5A5A5A5};
    wait_done(0, 1'b0);
    check("t4_readback_beats", beats_job, 1);

    // 5: zero-length job, start during its DONE cycle ignored
    d0 = done_cnt;
    start_job(16'h0000, 0);
    base_addr = 16'h0010;
    num_words = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_done_pulses", done_cnt - d0, 1);
    check("t5_busy_cycles", busy_cyc, 1);
    repeat (10) tick();
    check("t5_no_new_job", busy, 0);
    check("t5_no_valid", first_valid_cyc, -1);
    check("t5_done_once", done_cnt - d0, 1);

    // 6: reset mid-job, then a full job
    start_job(16'h0400, 8);
    w_ready = 1'b1;
    g = 0;
    while (beats_job < 2 && g < 50) begin
      tick();
      g++;
    end
    check("t6_two_beats", beats_job >= 2, 1);
    d0 = done_cnt;
    #3 rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_w_valid", w_valid, 0);
    check("t6_w_last", w_last, 0);
    check("t6_w_data", w_data, 0);
    check("t6_sram_addr", sram_addr, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("t6_no_done", done_cnt - d0, 0);
    start_job(16'h0400, 8);
    wait_done(2, 1'b0);
    check("t6_beats", beats_job, 8);

    // Randomized jobs with random ready and host traffic outside the job region
    for (int j = 0; j < 24; j++) begin
      b = 16'($urandom_range(0, 16'h1FC0) * 4);
      n = $urandom_range(0, 12);
      start_job(b, n);
      wait_done(2, 1'b1);
      check("rand_beats", beats_job, n);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
